// File: rtl/shift_sequencer_if.sv
// Request/response bundle for shift_sequencer: request side (in_valid/in_ready,
// operands, abort) and result side (out_valid/out_ready, res, carry).
interface shift_sequencer_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             carry;

  modport master (
    output in_valid, a, b, op, abort, out_ready,
    input  in_ready, out_valid, res, carry
  );

  modport slave (
    input  in_valid, a, b, op, abort, out_ready,
    output in_ready, out_valid, res, carry
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: one bit position per clock, IDLE/RUN/DONE handshake FSM.
// Define SHIFT_ROTATE_EN to compile in rotate-left for op=11 (otherwise op=11 is SLL).
module shift_sequencer #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  shift_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_ROTL = 2'b11
  } op_t;

  state_t             state;
  state_t             state_nxt;
  op_t                op_q;
  logic [WIDTH-1:0]   work;
  logic               work_carry;
  logic [SHAMT_W-1:0] count;
  logic [WIDTH-1:0]   res_q;
  logic               carry_q;
  logic [WIDTH-1:0]   step;
  logic               step_carry;
  logic               accept;

  // Upper shift-amount bits are deliberately ignored.
  logic unused_b;
  assign unused_b = ^bus.b[WIDTH-1:SHAMT_W];

  assign accept = (state == IDLE) && bus.in_valid && !bus.abort;

  // One-position step of the working register, plus the bit it pushes out.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    step       = {work[WIDTH-2:0], 1'b0};
    step_carry = work[WIDTH-1];
    case (op_q)
      OP_SRL: begin
        step       = {1'b0, work[WIDTH-1:1]};
        step_carry = work[0];
      end
      OP_SRA: begin
        step       = {work[WIDTH-1], work[WIDTH-1:1]};
        step_carry = work[0];
      end
`ifdef SHIFT_ROTATE_EN
      OP_ROTL: begin
        step       = {work[WIDTH-2:0], work[WIDTH-1]};
        step_carry = work[WIDTH-1];
      end
`endif
      default: begin
        step       = {work[WIDTH-2:0], 1'b0};
        step_carry = work[WIDTH-1];
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN: begin
        if (bus.abort)        state_nxt = IDLE;
        else if (count == '0) state_nxt = DONE;
      end
      DONE: begin
        if (bus.abort || bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A zero count still spends one RUN cycle, which keeps latency at shamt+1
  // uniformly; res/carry are only committed on the RUN->DONE edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= OP_SLL;
      work       <= '0;
      work_carry <= 1'b0;
      count      <= '0;
      res_q      <= '0;
      carry_q    <= 1'b0;
    end else if (accept) begin
      op_q       <= op_t'(bus.op);
      work       <= bus.a;
      work_carry <= 1'b0;
      count      <= bus.b[SHAMT_W-1:0];
    end else if (state == RUN && !bus.abort) begin
      if (count != '0) begin
        work       <= step;
        work_carry <= step_carry;
        count      <= count - 1'b1;
      end else begin
        res_q   <= work;
        carry_q <= work_carry;
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.res       = res_q;
  assign bus.carry     = carry_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer; build with and without
// SHIFT_ROTATE_EN, the op=11 expectation follows the macro.
module tb_shift_sequencer;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  shift_sequencer_if #(.WIDTH(32)) bus ();

  shift_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

`ifdef SHIFT_ROTATE_EN
  localparam logic [31:0] ROT_EXP = 32'h0000_0003;
`else
  localparam logic [31:0] ROT_EXP = 32'h0000_0002;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Drive inputs just after a rising edge; sample there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    bus.a  = $urandom;
    bus.b  = $urandom;
    bus.op = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_done(input string tag, input int exp_lat,
                           input logic [31:0] exp_res, input logic exp_carry);
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      tick();
      lat++;
    end
    check({tag, "_lat"},   lat,       exp_lat);
    check({tag, "_res"},   bus.res,   exp_res);
    check({tag, "_carry"}, bus.carry, exp_carry);
  endtask

  task automatic release_result(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_idle"}, {bus.in_ready, bus.out_valid}, 2'b10);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] op, input logic [31:0] exp_res,
                        input logic exp_carry, input int exp_lat);
    bus.a        = a;
    bus.b        = b;
    bus.op       = op;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    scramble();
    wait_done(tag, exp_lat, exp_res, exp_carry);
    release_result(tag);
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    bus.a        = a;
    bus.b        = b;
    bus.op       = op;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    scramble();
  endtask

  task automatic expect_silence(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = 2'b00;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;

    #1;
    check("rst_in_ready",  bus.in_ready,  1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_res",       bus.res,       32'h0);
    check("rst_carry",     bus.carry,     1'b0);

    // Request is pending while reset releases; the first live edge accepts it.
    bus.a        = 32'd1;
    bus.b        = 32'd2;
    bus.op       = 2'b00;
    bus.in_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("accept_after_reset", bus.in_ready, 1'b0);
    bus.in_valid = 1'b0;
    scramble();
    wait_done("sll_1_2", 3, 32'd4, 1'b0);
    release_result("sll_1_2");

    run_op("sll_5173",  32'd5173,      32'd11,   2'b00, 32'h00A1_A800, 1'b0, 12);
    run_op("sll_723",   32'd723,       32'd7,    2'b00, 32'd92544,     1'b0, 8);
    run_op("sra_msb",   32'h8000_0000, 32'd4,    2'b10, 32'hF800_0000, 1'b0, 5);
    run_op("srl_msb",   32'h8000_0000, 32'd4,    2'b01, 32'h0800_0000, 1'b0, 5);
    run_op("srl_b25",   32'h8000_0010, 32'h25,   2'b01, 32'h0400_0000, 1'b1, 6);
    run_op("sll_carry", 32'hC000_0000, 32'd2,    2'b00, 32'h0000_0000, 1'b1, 3);
    run_op("sra_carry", 32'h0000_0006, 32'd2,    2'b10, 32'h0000_0001, 1'b1, 3);
    run_op("sll_max",   32'h0000_0001, 32'd31,   2'b00, 32'h8000_0000, 1'b0, 32);
    run_op("sra_max",   32'h8000_0000, 32'd31,   2'b10, 32'hFFFF_FFFF, 1'b0, 32);
    run_op("op11",      32'h8000_0001, 32'd1,    2'b11, ROT_EXP,       1'b1, 2);

    // Zero shift after a carry=1 result, then a long stall in DONE.
    start_op(32'd15, 32'd0, 2'b00);
    wait_done("zero", 1, 32'd15, 1'b0);
    bus.in_valid = 1'b1;
    bus.a        = 32'hDEAD_BEEF;
    bus.b        = 32'd3;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_valid",    bus.out_valid, 1'b1);
      check("hold_res",      bus.res,       32'd15);
      check("hold_in_ready", bus.in_ready,  1'b0);
    end
    bus.in_valid = 1'b0;
    release_result("zero");

    // Asynchronous reset in the middle of a run.
    start_op(32'd9, 32'd12, 2'b00);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("arst_in_ready",  bus.in_ready,  1'b1);
    check("arst_out_valid", bus.out_valid, 1'b0);
    check("arst_res",       bus.res,       32'h0);
    check("arst_carry",     bus.carry,     1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_silence("arst_no_valid", 20);

    // Abort mid-run: back to IDLE on the next edge, previous result retained.
    run_op("pre_abort", 32'd3, 32'd1, 2'b00, 32'd6, 1'b0, 2);
    start_op(32'd9, 32'd12, 2'b00);
    repeat (3) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_run_state", {bus.in_ready, bus.out_valid}, 2'b10);
    check("abort_run_res",   bus.res, 32'd6);
    expect_silence("abort_no_valid", 20);

    // Abort while a result waits in DONE.
    start_op(32'd7, 32'd0, 2'b01);
    wait_done("pre_abort_done", 1, 32'd7, 1'b0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_done_state", {bus.in_ready, bus.out_valid}, 2'b10);

    // Abort in IDLE wins over a simultaneous request.
    bus.a        = 32'd1;
    bus.b        = 32'd0;
    bus.op       = 2'b00;
    bus.in_valid = 1'b1;
    bus.abort    = 1'b1;
    tick();
    check("abort_idle_no_accept", bus.in_ready, 1'b1);
    bus.abort = 1'b0;
    tick();
    check("accept_after_abort", bus.in_ready, 1'b0);
    bus.in_valid = 1'b0;
    scramble();
    wait_done("post_abort", 1, 32'd1, 1'b0);
    release_result("post_abort");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
